// File: rtl/gb_apu_pkg.sv
// Shared APU timing constants and types used by the frame sequencer.
package gb_apu_pkg;

    localparam int FS_STEP_W = 3;

    typedef logic [FS_STEP_W-1:0] fs_step_t;

    localparam fs_step_t FS_SWEEP_STEP_A = 3'd2;
    localparam fs_step_t FS_SWEEP_STEP_B = 3'd6;
    localparam fs_step_t FS_ENV_STEP     = 3'd7;

    localparam int unsigned GB_CLK_PER_512HZ = 8192;

    function automatic logic fs_is_sweep_step(input fs_step_t s);
        return (s == FS_SWEEP_STEP_A) || (s == FS_SWEEP_STEP_B);
    endfunction

endpackage

// File: rtl/gb_frame_sequencer_if.sv
// Control inputs and timing strobes of the frame sequencer, bundled for port connection.
interface gb_frame_sequencer_if;
    import gb_apu_pkg::*;

    logic     apu_enable;
    logic     div_bit;
    logic     clk_length;
    logic     clk_sweep;
    logic     clk_vol_env;
    logic     frame_tick;
    fs_step_t step;

    modport master (
        output apu_enable, div_bit,
        input  clk_length, clk_sweep, clk_vol_env, frame_tick, step
    );

    modport slave (
        input  apu_enable, div_bit,
        output clk_length, clk_sweep, clk_vol_env, frame_tick, step
    );

endinterface

// File: rtl/gb_tick_divider.sv
// 512 Hz tick source: either an internal prescaler or a falling-edge detector on DIV bit 4.
module gb_tick_divider #(
    parameter int unsigned CLK_DIV       = 8192,
    parameter bit          USE_DIV_INPUT = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic div_bit,
    output logic tick
);

    localparam logic [15:0] LP_CNT_LAST = 16'(CLK_DIV - 1);

    logic [15:0] r_div_cnt;
    logic        r_div_prev;
    logic        w_cnt_tick;
    logic        w_div_tick;

    assign w_cnt_tick = (r_div_cnt == LP_CNT_LAST);
    assign w_div_tick = r_div_prev & ~div_bit;
    assign tick       = enable & (USE_DIV_INPUT ? w_div_tick : w_cnt_tick);

    // div_prev tracks div_bit even while disabled so power-up never sees a false edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt  <= '0;
            r_div_prev <= 1'b0;
        end else begin
            r_div_prev <= div_bit;
            if (!enable || w_cnt_tick) begin
                r_div_cnt <= '0;
            end else begin
                r_div_cnt <= r_div_cnt + 16'd1;
            end
        end
    end

endmodule

// File: rtl/gb_frame_sequencer.sv
// APU frame sequencer: 8-step counter decoding length, sweep and envelope strobes from the 512 Hz tick.
module gb_frame_sequencer
    import gb_apu_pkg::*;
#(
    parameter int unsigned CLK_DIV       = GB_CLK_PER_512HZ,
    parameter bit          USE_DIV_INPUT = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    gb_frame_sequencer_if.slave   fs_if
);

    logic     w_tick;
    fs_step_t r_step;
    logic     r_frame_tick;
    logic     r_clk_length;
    logic     r_clk_sweep;
    logic     r_clk_vol_env;

    gb_tick_divider #(
        .CLK_DIV       (CLK_DIV),
        .USE_DIV_INPUT (USE_DIV_INPUT)
    ) u_tick_divider (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (fs_if.apu_enable),
        .div_bit (fs_if.div_bit),
        .tick    (w_tick)
    );

    // Disable wins over a coincident tick so power-down never leaks a strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_step        <= '0;
            r_frame_tick  <= 1'b0;
            r_clk_length  <= 1'b0;
            r_clk_sweep   <= 1'b0;
            r_clk_vol_env <= 1'b0;
        end else if (!fs_if.apu_enable) begin
            r_step        <= '0;
            r_frame_tick  <= 1'b0;
            r_clk_length  <= 1'b0;
            r_clk_sweep   <= 1'b0;
            r_clk_vol_env <= 1'b0;
        end else if (w_tick) begin
            r_frame_tick  <= 1'b1;
            r_clk_length  <= ~r_step[0];
            r_clk_sweep   <= fs_is_sweep_step(r_step);
            r_clk_vol_env <= (r_step == FS_ENV_STEP);
            r_step        <= r_step + fs_step_t'(1);
        end else begin
            r_frame_tick  <= 1'b0;
            r_clk_length  <= 1'b0;
            r_clk_sweep   <= 1'b0;
            r_clk_vol_env <= 1'b0;
        end
    end

    assign fs_if.step        = r_step;
    assign fs_if.frame_tick  = r_frame_tick;
    assign fs_if.clk_length  = r_clk_length;
    assign fs_if.clk_sweep   = r_clk_sweep;
    assign fs_if.clk_vol_env = r_clk_vol_env;

endmodule

// File: tb/tb_gb_frame_sequencer.sv
// Directed bench: internal-prescaler instance (CLK_DIV=4) and DIV-input instance side by side.
module tb_gb_frame_sequencer;

    localparam int TB_DIV = 4;

    logic clk;
    logic rst_n;

    gb_frame_sequencer_if if_i ();
    gb_frame_sequencer_if if_d ();

    gb_frame_sequencer #(.CLK_DIV(TB_DIV), .USE_DIV_INPUT(1'b0)) u_int (
        .clk   (clk),
        .rst_n (rst_n),
        .fs_if (if_i.slave)
    );

    gb_frame_sequencer #(.CLK_DIV(TB_DIV), .USE_DIV_INPUT(1'b1)) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .fs_if (if_d.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc;
    logic [2:0] exp_step;
    int         n_len, n_sw, n_env, n_ft;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Expected strobes for executing step s
    task automatic exp_for_step(input logic [2:0] s, output logic l, output logic sw, output logic e);
        l  = ~s[0];
        sw = (s == 3'd2) || (s == 3'd6);
        e  = (s == 3'd7);
    endtask

    task automatic run_int(input int n);
        logic e_ft, e_l, e_sw, e_e;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            cyc++;
            e_ft = 1'b0; e_l = 1'b0; e_sw = 1'b0; e_e = 1'b0;
            if (cyc % TB_DIV == 0) begin
                e_ft = 1'b1;
                exp_for_step(exp_step, e_l, e_sw, e_e);
                exp_step = exp_step + 3'd1;
            end
            chk("int_frame_tick", if_i.frame_tick, e_ft);
            chk("int_clk_length", if_i.clk_length, e_l);
            chk("int_clk_sweep", if_i.clk_sweep, e_sw);
            chk("int_clk_vol_env", if_i.clk_vol_env, e_e);
            chk("int_step", if_i.step, exp_step);
            n_len += int'(if_i.clk_length);
            n_sw  += int'(if_i.clk_sweep);
            n_env += int'(if_i.clk_vol_env);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ft"}, if_i.frame_tick, 1'b0);
        chk({tag, "_len"}, if_i.clk_length, 1'b0);
        chk({tag, "_sw"}, if_i.clk_sweep, 1'b0);
        chk({tag, "_env"}, if_i.clk_vol_env, 1'b0);
        chk({tag, "_step"}, if_i.step, 3'd0);
    endtask

    initial begin
        logic d_prev, v, e_ft, e_l, e_sw, e_e;
        rst_n = 1'b0;
        if_i.apu_enable = 1'b0; if_i.div_bit = 1'b0;
        if_d.apu_enable = 1'b0; if_d.div_bit = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_idle("reset");

        // Normal run: 64 cycles, 16 ticks, two full frames
        rst_n = 1'b1;
        if_i.apu_enable = 1'b1;
        cyc = 0; exp_step = 3'd0;
        n_len = 0; n_sw = 0; n_env = 0;
        run_int(64);
        chk("cnt_length_64", n_len, 8);
        chk("cnt_sweep_64", n_sw, 4);
        chk("cnt_env_64", n_env, 2);

        // Advance to step 5, then drop enable for 3 cycles
        run_int(20);
        chk("pre_drop_step", if_i.step, 3'd5);
        if_i.apu_enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk_idle("disabled");
        end
        if_i.apu_enable = 1'b1;
        cyc = 0; exp_step = 3'd0;
        run_int(8);

        // Enable falls on the very edge that would tick
        run_int(3);
        if_i.apu_enable = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk_idle("coincident");
        end
        if_i.apu_enable = 1'b1;
        cyc = 0; exp_step = 3'd0;
        run_int(12);
        chk("pre_reset_sweep", if_i.clk_sweep, 1'b1);

        // Async reset mid-cycle while clk_sweep is high
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle("async_reset");
        #1;
        rst_n = 1'b1;
        cyc = 0; exp_step = 3'd0;
        run_int(8);

        // DIV mode: hold div_bit high across enable, no tick
        if_d.div_bit = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        if_d.apu_enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("div_hold_ft", if_d.frame_tick, 1'b0);
            chk("div_hold_step", if_d.step, 3'd0);
        end

        // Toggle div_bit with period 10 (5 low, 5 high)
        d_prev = 1'b1; exp_step = 3'd0; n_ft = 0;
        for (int i = 0; i < 40; i++) begin
            v = ((i / 5) % 2 == 0) ? 1'b0 : 1'b1;
            if_d.div_bit = v;
            @(posedge clk); #1;
            e_ft = d_prev & ~v;
            e_l = 1'b0; e_sw = 1'b0; e_e = 1'b0;
            if (e_ft) begin
                exp_for_step(exp_step, e_l, e_sw, e_e);
                exp_step = exp_step + 3'd1;
            end
            chk("div_ft", if_d.frame_tick, e_ft);
            chk("div_len", if_d.clk_length, e_l);
            chk("div_sw", if_d.clk_sweep, e_sw);
            chk("div_env", if_d.clk_vol_env, e_e);
            chk("div_step", if_d.step, exp_step);
            n_ft += int'(if_d.frame_tick);
            d_prev = v;
        end
        chk("div_tick_count", n_ft, 4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/gb_frame_sequencer.md
# gb_frame_sequencer

Generates the APU's low-rate timing strobes: a 512 Hz base tick drives an 8-step sequencer. The sequencer emits single-cycle `clk_length` (256 Hz), `clk_sweep` (128 Hz) and `clk_vol_env` (64 Hz) strobes, which feed the length counters, the channel-1 frequency sweep and the envelope functions of channels 1, 2 and 4. It is the producer side of the `clk_vol_env` strobe that the envelope logic consumes. Gating follows APU power (NR52 bit 7).

## Interface
Parameters:
- `CLK_DIV`, 8192: `clk` cycles per 512 Hz step (4.194304 MHz / 512); legal range 2..65535.
- `USE_DIV_INPUT`, 0: 1 = step on falling edge of `div_bit`; 0 = internal prescaler.

Ports:
- `clk` input 1: system clock; one clock domain, all logic on posedge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `apu_enable` input 1: APU power; low holds the block in its idle state.
- `div_bit` input 1: timer DIV bit 4, synchronous to `clk`; ignored when `USE_DIV_INPUT`=0.
- `clk_length` output 1: one-cycle strobe, steps 0, 2, 4, 6.
- `clk_sweep` output 1: one-cycle strobe, steps 2, 6.
- `clk_vol_env` output 1: one-cycle strobe, step 7.
- `frame_tick` output 1: one-cycle strobe on every step (512 Hz).
- `step` output 3: index of the next step to execute.

## Operation
- State: prescaler `div_cnt` (16 bits), `step` (3 bits), `div_prev` (1 bit), and registered strobes.
- Tick source, internal mode: `div_cnt` counts 0..CLK_DIV-1 while `apu_enable`=1. The count wraps to 0, and the tick fires, on the edge where it is CLK_DIV-1.
- Tick source, DIV mode: the tick fires on the edge where `div_prev`=1 and `div_bit`=0. `div_prev` samples `div_bit` every cycle regardless of `apu_enable`, so enabling the APU never creates a spurious edge.
- On a tick, the sequencer executes step S = `step`:
  - `frame_tick` <= 1.
  - `clk_length` <= (S[0]==0).
  - `clk_sweep` <= (S==2 or S==6).
  - `clk_vol_env` <= (S==7).
  - `step` <= S+1, mod 8; 7 wraps to 0.
- Without a tick, all strobes <= 0. Strobes are never high for two consecutive cycles.
- `apu_enable`=0 forces `div_cnt`=0, `step`=0 and all strobes 0, effective on the next edge. It overrides a coincident tick.
- Re-enable: the first tick occurs CLK_DIV cycles after the first cycle with `apu_enable`=1 in internal mode, or on the next `div_bit` falling edge in DIV mode. That first tick executes step 0.
- Reset (`rst_n`=0): `div_cnt`=0, `step`=0, `div_prev`=0, all strobes 0, asynchronously.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- Internal mode: the tick edge is the one where `div_cnt`=CLK_DIV-1. Strobes are high for exactly the following cycle, and `step` shows the incremented value in that same cycle.
- DIV mode: strobes are high in the cycle after the edge at which `div_bit`=0 is sampled with `div_prev`=1. Latency is 1 cycle from the sampled falling edge.
- Period: `frame_tick` every CLK_DIV cycles, `clk_length` every 2·CLK_DIV, `clk_sweep` every 4·CLK_DIV, `clk_vol_env` every 8·CLK_DIV.
- Within one 8-step frame, the order is L, –, L+S, –, L, –, L+S, E.
- Reset release mid-count restarts from the idle state. There is no partial frame.

## Structure
- Shared package `gb_apu_pkg`:
  - `FS_STEP_W` = 3.
  - Step constants `FS_SWEEP_STEP_A` = 2, `FS_SWEEP_STEP_B` = 6, `FS_ENV_STEP` = 7.
  - `GB_CLK_PER_512HZ` = 8192.
  - Typedef `fs_step_t` (logic [2:0]).
- One sub-module `gb_tick_divider`: the parameterised prescaler / DIV falling-edge detector producing a single-cycle `tick`, with `clk`, `rst_n`, `enable`, `div_bit`. The top level holds the step counter and the strobe decode.

## Test plan
- Reset, internal mode, CLK_DIV=4, `apu_enable`=1 for 64 cycles:
  - `frame_tick` at cycles 4, 8, 12, ….
  - `clk_length` at steps 0, 2, 4, 6 (8 per 64 cycles).
  - `clk_sweep` at 2 and 6 (4 per 64 cycles).
  - `clk_vol_env` once per 32 cycles.
  - Each strobe is exactly 1 cycle wide.
- Step wrap: run past step 7 → `clk_vol_env`=1 with `step`=0 in the same cycle; the next tick produces `clk_length` only.
- `apu_enable` dropped at `step`=5 for 3 cycles, then raised:
  - `step`=0 and no strobes while low.
  - First `frame_tick` exactly CLK_DIV cycles after re-enable, with `clk_length`=1 (step 0).
- `apu_enable` falls on the same edge as a tick: no strobe is emitted; `step`=0.
- DIV mode:
  - Toggle `div_bit` with period 10: one `frame_tick` 1 cycle after each 1→0 transition, none on 0→1.
  - Hold `div_bit`=1 while enabling → no tick until the first falling edge.
- Async reset asserted mid-cycle while `clk_sweep`=1 → all outputs 0 immediately (before the next edge); `step`=0 after release.
